// File: rtl/view_matrix_gen.sv
// Fixed-point yaw+translate view matrix; latency start->out_valid is 1 edge (mode 0) or 6 edges (mode 1).
// Result held in DONE until out_ready; start ignored outside IDLE.
module view_matrix_gen #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                mode,
  input  logic [W-1:0]        x_pos,
  input  logic [W-1:0]        y_pos,
  input  logic [W-1:0]        z_pos,
  input  logic [W-1:0]        cos_yaw,
  input  logic [W-1:0]        sin_yaw,
  input  logic                out_ready,
  output logic                busy,
  output logic                out_valid,
  output logic [15:0][W-1:0]  view_matrix,
  output logic                sat
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, SUM, DONE} state_t;

  state_t state, state_nxt;

  logic signed [W-1:0]   ex, ey, ez, c, s;
  logic signed [W-1:0]   op_a, op_b;
  logic signed [2*W-1:0] full_prod;
  logic signed [2*W-1:0] prod [4];
  logic [1:0]            mul_idx;
  logic                  mul_v;

  logic [2*W:0] tx_w, ty_w, tz_w, ns_w;
  logic [W:0]   tx_c, ty_c, tz_c, ns_c;

  // Returns {saturated, value}: clamps a (2W+1)-bit signed value to W bits.
  function automatic logic [W:0] clamp(input logic [2*W:0] v);
    if ((&v[2*W:W-1]) || (~|v[2*W:W-1]))
      clamp = {1'b0, v[W-1:0]};
    else
      clamp = {1'b1, v[2*W], {(W-1){~v[2*W]}}};
  endfunction

  // Operands are registered one edge before the multiply, so the last product
  // retires in the first SUM cycle and SUM waits for it before writing out.
  assign full_prod = op_a * op_b;

  assign tx_w = {prod[1][2*W-1], prod[1]} - {prod[0][2*W-1], prod[0]};
  assign tz_w = '0 - ({prod[2][2*W-1], prod[2]} + {prod[3][2*W-1], prod[3]});
  assign ty_w = '0 - {{(W+1){ey[W-1]}}, ey};
  assign ns_w = '0 - {{(W+1){s[W-1]}}, s};

  assign tx_c = clamp(tx_w);
  assign ty_c = clamp(ty_w);
  assign tz_c = clamp(tz_w);
  assign ns_c = clamp(ns_w);

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = mode ? MUL0 : SUM;
      MUL0:    state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = MUL3;
      MUL3:    state_nxt = SUM;
      SUM:     if (!mul_v) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex        <= '0;
      ey        <= '0;
      ez        <= '0;
      c         <= '0;
      s         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mul_idx   <= '0;
      mul_v     <= 1'b0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      for (int i = 0; i < 4; i++) prod[i] <= '0;
      for (int i = 0; i < 16; i++) view_matrix[i] <= (i % 5 == 0) ? ONE : '0;
    end else begin
      mul_v <= 1'b0;
      if (mul_v) prod[mul_idx] <= full_prod >>> FRAC;
      case (state)
        IDLE: if (start) begin
          ex <= x_pos;
          ey <= y_pos;
          ez <= z_pos;
          if (mode) begin
            c <= cos_yaw;
            s <= sin_yaw;
          end else begin
            // c=ONE, s=0 makes every product trivial, so preload them.
            c       <= ONE;
            s       <= '0;
            prod[0] <= {{W{x_pos[W-1]}}, x_pos};
            prod[1] <= '0;
            prod[2] <= '0;
            prod[3] <= {{W{z_pos[W-1]}}, z_pos};
          end
        end
        MUL0: begin op_a <= c; op_b <= ex; mul_idx <= 2'd0; mul_v <= 1'b1; end
        MUL1: begin op_a <= s; op_b <= ez; mul_idx <= 2'd1; mul_v <= 1'b1; end
        MUL2: begin op_a <= s; op_b <= ex; mul_idx <= 2'd2; mul_v <= 1'b1; end
        MUL3: begin op_a <= c; op_b <= ez; mul_idx <= 2'd3; mul_v <= 1'b1; end
        SUM: if (!mul_v) begin
          view_matrix[0]  <= c;
          view_matrix[1]  <= '0;
          view_matrix[2]  <= ns_c[W-1:0];
          view_matrix[3]  <= tx_c[W-1:0];
          view_matrix[4]  <= '0;
          view_matrix[5]  <= ONE;
          view_matrix[6]  <= '0;
          view_matrix[7]  <= ty_c[W-1:0];
          view_matrix[8]  <= s;
          view_matrix[9]  <= '0;
          view_matrix[10] <= c;
          view_matrix[11] <= tz_c[W-1:0];
          view_matrix[12] <= '0;
          view_matrix[13] <= '0;
          view_matrix[14] <= '0;
          view_matrix[15] <= ONE;
          sat       <= tx_c[W] | ty_c[W] | tz_c[W] | ns_c[W];
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
